// File: rtl/rate_divider_bank_pkg.sv
// rtl/rate_divider_bank_pkg.sv - shared parameters and helpers for the rate divider bank
package rate_divider_bank_pkg;

  localparam int DEFAULT_WIDTH = 28;

  // Channel index width; a single-channel bank still carries a one-bit select.
  function automatic int ch_index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rate_divider_bank_if.sv
// rtl/rate_divider_bank_if.sv - rate register write/readback port
interface rate_divider_bank_if
  import rate_divider_bank_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int CHW = ch_index_width(N_CH);

  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_rate;
  logic             wr_restart;
  logic [WIDTH-1:0] rd_rate;

  modport master (
    output wr_en, wr_ch, wr_rate, wr_restart,
    input  rd_rate
  );

  modport slave (
    input  wr_en, wr_ch, wr_rate, wr_restart,
    output rd_rate
  );

endinterface

// File: rtl/rate_divider_channel.sv
// rtl/rate_divider_channel.sv - one programmable divider channel with tick and square outputs
module rate_divider_channel #(
  parameter int               WIDTH        = 28,
  parameter logic [WIDTH-1:0] DEFAULT_RATE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic             restart,
  input  logic [WIDTH-1:0] wr_rate,
  output logic [WIDTH-1:0] rate,
  output logic             tick,
  output logic             square
);

  logic [WIDTH-1:0] cnt;

  // Rate register; reloads below read the pre-write value on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate <= DEFAULT_RATE;
    end else if (wr) begin
      rate <= wr_rate;
    end
  end

  // Down-counter: sync beats restart beats terminal count beats decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      tick   <= 1'b0;
      square <= 1'b0;
    end else if (sync) begin
      cnt    <= rate;
      tick   <= 1'b0;
      square <= 1'b0;
    end else if (wr && restart) begin
      cnt    <= wr_rate;
      tick   <= 1'b0;
      square <= 1'b0;
    end else if (!en) begin
      tick   <= 1'b0;
    end else if (cnt == '0) begin
      cnt    <= rate;
      tick   <= 1'b1;
      square <= ~square;
    end else begin
      cnt    <= cnt - 1'b1;
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/rate_divider_bank.sv
// rtl/rate_divider_bank.sv - bank of independent programmable rate dividers
module rate_divider_bank
  import rate_divider_bank_pkg::*;
#(
  parameter int               N_CH         = 4,
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_RATE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync,
  rate_divider_bank_if.slave  bus,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     square
);

  localparam int CHW = ch_index_width(N_CH);

  logic [WIDTH-1:0] rate_q [N_CH];
  logic [N_CH-1:0]  wr_sel;

  // Channel selects beyond N_CH-1 match no instance, so such writes drop out.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = bus.wr_en && (bus.wr_ch == CHW'(i));

    rate_divider_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_RATE (DEFAULT_RATE)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ch_en[i]),
      .sync    (sync),
      .wr      (wr_sel[i]),
      .restart (bus.wr_restart),
      .wr_rate (bus.wr_rate),
      .rate    (rate_q[i]),
      .tick    (tick[i]),
      .square  (square[i])
    );
  end

  // Readback mux; an out-of-range select reads as zero.
  always_comb begin
    bus.rd_rate = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.wr_ch == CHW'(i)) begin
        bus.rd_rate = rate_q[i];
      end
    end
  end

endmodule

// File: tb/tb_rate_divider_bank.sv
// tb/tb_rate_divider_bank.sv - scoreboard bench for rate_divider_bank against a timeline model
module tb_rate_divider_bank;

  localparam int N  = 4;
  localparam int W  = 28;

  typedef struct {
    int           cyc;
    logic [N-1:0] tick;
    logic [N-1:0] square;
    logic [W-1:0] rd_rate;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic         sync = 1'b0;
  logic [N-1:0] tick;
  logic [N-1:0] square;

  rate_divider_bank_if #(.N_CH(N), .WIDTH(W)) bus ();

  rate_divider_bank #(.N_CH(N), .WIDTH(W), .DEFAULT_RATE('0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ch_en   (ch_en),
    .sync    (sync),
    .bus     (bus),
    .tick    (tick),
    .square  (square)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb [$];

  // Timeline model: count enabled edges per channel and note the edge index
  // at which the next tick is due; square is the parity of ticks since the
  // last phase anchor (reset, sync or restart).
  longint       m_ecnt  [N];
  longint       m_due   [N];
  longint       m_ticks [N];
  logic [W-1:0] m_rate  [N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_rate[c]  = '0;
      m_ecnt[c]  = 0;
      m_due[c]   = 1;
      m_ticks[c] = 0;
    end
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and queue the expected result.
  task automatic drive(input logic [N-1:0] en, input logic s, input logic we,
                       input logic [1:0] ch, input logic [W-1:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    cyc++;
    reset_n        = 1'b1;
    ch_en          = en;
    sync           = s;
    bus.wr_en      = we;
    bus.wr_ch      = ch;
    bus.wr_rate    = r;
    bus.wr_restart = rs;
    e.cyc = cyc;
    for (int c = 0; c < N; c++) begin
      logic [W-1:0] old_rate;
      logic         hit;
      old_rate    = m_rate[c];
      hit         = we && (int'(ch) == c);
      e.tick[c]   = 1'b0;
      if (s) begin
        m_due[c]   = m_ecnt[c] + longint'(old_rate) + 1;
        m_ticks[c] = 0;
      end else if (hit && rs) begin
        m_due[c]   = m_ecnt[c] + longint'(r) + 1;
        m_ticks[c] = 0;
      end else if (en[c]) begin
        m_ecnt[c]++;
        if (m_ecnt[c] == m_due[c]) begin
          e.tick[c]  = 1'b1;
          m_ticks[c]++;
          m_due[c]   = m_ecnt[c] + longint'(old_rate) + 1;
        end
      end
      if (hit) m_rate[c] = r;
      e.square[c] = m_ticks[c][0];
    end
    e.rd_rate = m_rate[ch];
    sb.push_back(e);
  endtask

  task automatic run(input int n, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) drive(en, 1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  // Assert reset between edges, check the asynchronous clear, hold across one edge.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    cyc++;
    reset_n   = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_ch = 2'd0;
    sync      = 1'b0;
    #1;
    check("async_tick",   W'(tick),   '0);
    check("async_square", W'(square), '0);
    check("async_rdrate", bus.rd_rate, '0);
    model_reset();
    e.cyc     = cyc;
    e.tick    = '0;
    e.square  = '0;
    e.rd_rate = '0;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("tick",    W'(tick),    W'(e.tick));
      check("square",  W'(square),  W'(e.square));
      check("rd_rate", bus.rd_rate, e.rd_rate);
    end
  end

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_ch      = 2'd0;
    bus.wr_rate    = '0;
    bus.wr_restart = 1'b0;
    model_reset();
    do_reset();

    // Default rate 0: tick every cycle, square toggles every cycle.
    run(6, 4'hF);

    // ch1 rate 4 without restart, then ch2 rate 9 with restart.
    drive(4'hF, 1'b0, 1'b1, 2'd1, 28'd4, 1'b0);
    run(23, 4'hF);
    drive(4'hF, 1'b0, 1'b1, 2'd2, 28'd9, 1'b1);
    run(22, 4'hF);

    // Rates 3/5/7 on ch0..2 then a global sync.
    drive(4'hF, 1'b0, 1'b1, 2'd0, 28'd3, 1'b0);
    drive(4'hF, 1'b0, 1'b1, 2'd1, 28'd5, 1'b0);
    drive(4'hF, 1'b0, 1'b1, 2'd2, 28'd7, 1'b0);
    run(11, 4'hF);
    drive(4'hF, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    run(18, 4'hF);

    // ch0 rate 6, enable dropped for three cycles mid-period.
    drive(4'hF, 1'b0, 1'b1, 2'd0, 28'd6, 1'b1);
    run(3, 4'hF);
    run(3, 4'hE);
    run(12, 4'hF);

    // Full-scale rate on ch3, then rewritten to 2 with restart.
    drive(4'hF, 1'b0, 1'b1, 2'd3, 28'hFFF_FFFF, 1'b1);
    run(6, 4'hF);
    drive(4'hF, 1'b0, 1'b1, 2'd3, 28'd2, 1'b1);
    run(7, 4'hF);

    // Reset pulse mid-count, then resume.
    do_reset();
    run(4, 4'hF);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] en;
      for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 7) != 0);
      drive(en,
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)),
            W'($urandom_range(0, 9)),
            1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_divider_bank.md
# rate_divider_bank

Bank of N_CH independent programmable rate dividers sharing one clock, used to generate MIDI clock ticks, LED blink rates and note-timing strobes from the system clock. Each channel emits a one-cycle tick every (rate+1) enabled cycles plus a 50%-duty square wave. Rates are written through a single register-write port and can be phase-aligned across channels with a global sync strobe.

## Interface
- N_CH, 4: number of channels (≥1)
- WIDTH, 28: rate and counter width per channel
- DEFAULT_RATE, 0: rate register value after reset
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ch_en  in  N_CH  per-channel count enable (level)
- sync  in  1  one-cycle strobe; restarts all channels in phase
- wr_en  in  1  write strobe for rate register
- wr_ch  in  CHW  target channel, CHW = max(1, clog2(N_CH))
- wr_rate  in  WIDTH  new rate value
- wr_restart  in  1  qualifies wr_en: restart target channel immediately
- rd_rate  out  WIDTH  rate register of channel wr_ch (combinational readback)
- tick  out  N_CH  registered one-cycle pulse per period
- square  out  N_CH  registered, toggles on every tick

## Operation
- Per channel: rate_reg (WIDTH), cnt (WIDTH, full width, no truncation), tick, square.
- Reset (reset_n low, async): rate_reg = DEFAULT_RATE, cnt = 0, tick = 0, square = 0.
- Per-cycle priority per channel: sync > write-with-restart > terminal count > decrement.
- sync: cnt ← rate_reg (current, pre-write value), tick ← 0, square ← 0; applies to all channels regardless of ch_en.
- wr_en with wr_ch = c: rate_reg[c] ← wr_rate on that edge. wr_ch ≥ N_CH: write ignored.
- wr_restart=1 (and no sync): cnt[c] ← wr_rate, tick ← 0, square ← 0.
- wr_restart=0: new rate takes effect at next reload; current period completes unchanged.
- ch_en[c]=0 (no sync/restart): cnt, square hold; tick ← 0.
- ch_en[c]=1, cnt=0: tick ← 1, square ← ~square, cnt ← rate_reg (value before any same-cycle write).
- ch_en[c]=1, cnt≠0: cnt ← cnt−1, tick ← 0.
- Period = rate+1 enabled cycles; rate=0 gives tick every enabled cycle and square toggling every cycle. rate = 2^WIDTH−1 must work without overflow.
- square period = 2·(rate+1) cycles.

## Timing
- tick and square registered; no combinational path from inputs to tick/square.
- rd_rate is combinational from wr_ch and rate_reg; same-cycle write not reflected until next cycle.
- After reset release with ch_en=1: first tick on first rising edge (cnt=0), next after rate+1 cycles.
- After sync on edge k: first tick on edge k+rate+1 (counting enabled cycles).
- After write-with-restart on edge k: first tick on edge k+wr_rate+1.
- Write without restart coincident with terminal count: that reload uses old rate; new rate from the following reload.
- Reset asserted mid-period: all state cleared immediately, outputs low asynchronously.

## Structure
- Shared package: WIDTH default, ch_index width function (max(1, clog2)).
- Sub-module rate_divider_channel: one channel (rate_reg, cnt, tick, square), inputs en, sync, wr, restart, wr_rate. Top generates N_CH instances and decodes wr_ch into per-channel wr strobes and rd_rate mux.

## Test plan
- Reset, ch_en=1, DEFAULT_RATE=0 → tick high every cycle on all channels, square toggles each cycle.
- Write ch1 rate=4 no restart mid-period → ch1 finishes old period, then ticks every 5 cycles; square period 10; other channels unaffected.
- Write ch2 rate=9 with restart on edge k → ch2 tick on k+10, k+20; square cleared at k.
- Channels rates 3,5,7 running; sync on edge k → all squares 0, ticks at k+4/k+6/k+8 respectively.
- ch_en[0] dropped for 3 cycles mid-period at rate=6 → tick delayed by exactly 3 cycles, square unchanged during hold.
- WIDTH=28, rate=2^28−1 loaded then rewritten to 2 with restart → no wrap; reset_n pulse mid-count clears tick/square/cnt immediately.
